// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing the multicycle RV32I-subset datapath
module multicycle_control #(
    parameter int ULA_W      = 3,
    parameter int CNT_W      = 16,
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit ENABLE_JAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic [6:0]       OP,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic [ULA_W-1:0] ULAControl,
    output logic [3:0]       state_o,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [ULA_W-1:0] ULA_ADD = ULA_W'(3'b000);
    localparam logic [ULA_W-1:0] ULA_SUB = ULA_W'(3'b001);
    localparam logic [ULA_W-1:0] ULA_AND = ULA_W'(3'b010);
    localparam logic [ULA_W-1:0] ULA_OR  = ULA_W'(3'b011);
    localparam logic [ULA_W-1:0] ULA_SLT = ULA_W'(3'b101);

    logic [3:0]       state, next_state, cur;
    logic             live, pc_update, branch, mem_write, ir_write, reg_write;
    logic             br_legal, retire;
    logic [1:0]       alu_op;
    logic [ULA_W-1:0] funct_ctl;
    logic             unused_funct7;

    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    // While in reset the outputs already show the FETCH view of the FSM
    assign cur      = rst ? S_FETCH : state;
    assign live     = step_en & ~rst;
    assign br_legal = (OP == OP_BR) && (Funct3 == 3'b000 || (Funct3 == 3'b001 && ENABLE_BNE));
    assign retire   = state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB || state == S_BRANCH;

    // Next-state selection
    always_comb begin
        next_state = S_HALT;
        case (state)
            S_FETCH:    next_state = S_DECODE;
            S_DECODE:   next_state = (OP == OP_LW || OP == OP_SW) ? S_MEMADR :
                                     (OP == OP_R)                 ? S_EXECR  :
                                     (OP == OP_I)                 ? S_EXECI  :
                                     br_legal                     ? S_BRANCH :
                                     (OP == OP_JAL && ENABLE_JAL) ? S_JAL    : S_HALT;
            S_MEMADR:   next_state = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: next_state = S_FETCH;
            default:    next_state = S_HALT;
        endcase
    end

    // Moore output decode from the (reset-adjusted) current state
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ULASrcA   = 2'b00;
        ULASrcB   = 2'b00;
        alu_op    = ALU_ADD;
        case (cur)
            S_FETCH: begin
                ir_write  = 1'b1;
                ULASrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ULASrcA = 2'b01;
                ULASrcB = 2'b01;
            end
            S_MEMADR: begin
                ULASrcA = 2'b10;
                ULASrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                ULASrcA = 2'b10;
                alu_op  = ALU_FUNCT;
            end
            S_EXECI: begin
                ULASrcA = 2'b10;
                ULASrcB = 2'b01;
                alu_op  = ALU_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                ULASrcA   = 2'b01;
                ULASrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BRANCH: begin
                ULASrcA = 2'b10;
                alu_op  = ALU_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // ULA operation: fixed add/sub, or decoded from funct fields
    always_comb begin
        funct_ctl  = (Funct3 == 3'b000) ? ((OP[5] & Funct7[5]) ? ULA_SUB : ULA_ADD) :
                     (Funct3 == 3'b010) ? ULA_SLT :
                     (Funct3 == 3'b110) ? ULA_OR  :
                     (Funct3 == 3'b111) ? ULA_AND : ULA_ADD;
        ULAControl = (alu_op == ALU_SUB)   ? ULA_SUB :
                     (alu_op == ALU_FUNCT) ? funct_ctl : ULA_ADD;
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        ImmSrc = (OP == OP_SW)  ? 2'b01 :
                 (OP == OP_BR)  ? 2'b10 :
                 (OP == OP_JAL) ? 2'b11 : 2'b00;
    end

    // Write enables are suppressed in reset and while single-step holds the FSM
    assign PCWrite  = live & (pc_update | (branch & (Zero ^ Funct3[0])));
    assign MemWrite = live & mem_write;
    assign IRWrite  = live & ir_write;
    assign RegWrite = live & reg_write;
    assign state_o  = cur;
    assign halted   = cur == S_HALT;

    // State register and cycle/instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (step_en) begin
            state <= next_state;
            if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
endmodule
